lfsr_seq_gen: RTL and testbench

- Parametrised Fibonacci LFSR sequencer.
- Successor to the fixed 20-bit trigger-stepped LFSR counter: generalised width and tap polynomial, explicit seed-load path, all-zero lockup protection, terminal-value match with freeze, and an advance counter.
- Sits beside the AES datapath; steps only on a trigger/enable and reports when a programmed sequence value is reached.

---
 rtl/lfsr_seq_gen.sv | 115 +++++++++++
 tb/tb_lfsr_seq_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_gen.sv
// Parametrised Fibonacci LFSR sequencer with seed load, zero-seed substitution,
// terminal-value match/freeze and saturating advance counter. Optional: LFSR_PERIOD_EN.
module lfsr_seq_gen #(
    parameter int                 WIDTH        = 20,
    parameter logic [WIDTH-1:0]   TAPS         = 20'h08881,
    parameter logic [WIDTH-1:0]   SEED_DEFAULT = 20'h00001,
    parameter int                 CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed,
    input  logic              en,
    input  logic              match_en,
    input  logic [WIDTH-1:0]  match_val,
    output logic [WIDTH-1:0]  lfsr,
    output logic [1:0]        state_o,
    output logic              hit,
    output logic [CNT_W-1:0]  steps,
`ifdef LFSR_PERIOD_EN
    output logic              period,
`endif
    output logic              lockup
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              advance;
    logic              feedback;
    logic [WIDTH-1:0]  lfsr_q;
    logic [WIDTH-1:0]  lfsr_next;
    logic [WIDTH-1:0]  seed_value;
    logic [CNT_W-1:0]  steps_q;
    logic              hit_q;
    logic              lockup_q;

    assign feedback   = ^(lfsr_q & TAPS);
    assign lfsr_next  = {feedback, lfsr_q[WIDTH-1:1]};
    // An all-zero seed would lock the register; substitute the default instead.
    assign seed_value = (seed == '0) ? SEED_DEFAULT : seed;

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (seed_load) state_d = RUN;
            end
            RUN: begin
                if (seed_load) begin
                    state_d = RUN;
                end else if (en) begin
                    advance = 1'b1;
                    if (match_en && (lfsr_next == match_val)) state_d = HIT;
                end
            end
            HIT: begin
                if (seed_load) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED_DEFAULT;
            steps_q  <= '0;
            hit_q    <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hit_q    <= (state_d == HIT);
            lockup_q <= seed_load && (seed == '0);
            if (seed_load) begin
                lfsr_q  <= seed_value;
                steps_q <= '0;
            end else if (advance) begin
                lfsr_q <= lfsr_next;
                if (steps_q != '1) steps_q <= steps_q + CNT_W'(1);
            end
        end
    end

`ifdef LFSR_PERIOD_EN
    logic [WIDTH-1:0] start_val;
    logic             period_q;

    // start_val holds the first value of the current sequence so wrap-around can be flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_val <= SEED_DEFAULT;
            period_q  <= 1'b0;
        end else begin
            if (seed_load) start_val <= seed_value;
            period_q <= advance && (lfsr_next == start_val);
        end
    end

    assign period = period_q;
`endif

    assign lfsr    = lfsr_q;
    assign state_o = state_q;
    assign hit     = hit_q;
    assign steps   = steps_q;
    assign lockup  = lockup_q;

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Testbench for lfsr_seq_gen: directed vector table, small-width saturation/period
// sequence, and randomized run against a behavioural sequence model.
module tb_lfsr_seq_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, default parameters
    logic        rst, seed_load, en, match_en;
    logic [19:0] seed, match_val, lfsr;
    logic [1:0]  state_o;
    logic        hit, lockup;
    logic [15:0] steps;
`ifdef LFSR_PERIOD_EN
    logic        period;
`endif

    // Small instance: 4-bit register, 4-bit counter
    logic        s_rst, s_seed_load, s_en;
    logic [3:0]  s_seed, s_lfsr, s_steps;
    logic [1:0]  s_state;
    logic        s_hit, s_lockup;
`ifdef LFSR_PERIOD_EN
    logic        s_period;
`endif

    lfsr_seq_gen dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .en(en),
        .match_en(match_en), .match_val(match_val), .lfsr(lfsr), .state_o(state_o),
        .hit(hit), .steps(steps),
`ifdef LFSR_PERIOD_EN
        .period(period),
`endif
        .lockup(lockup)
    );

    lfsr_seq_gen #(.WIDTH(4), .TAPS(4'h3), .SEED_DEFAULT(4'h1), .CNT_W(4)) dut_s (
        .clk(clk), .rst(s_rst), .seed_load(s_seed_load), .seed(s_seed), .en(s_en),
        .match_en(1'b0), .match_val(4'h0), .lfsr(s_lfsr), .state_o(s_state),
        .hit(s_hit), .steps(s_steps),
`ifdef LFSR_PERIOD_EN
        .period(s_period),
`endif
        .lockup(s_lockup)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one step of the sequence computed by counting tapped ones.
    function automatic logic [31:0] adv(input logic [31:0] v, input logic [31:0] taps, input int w);
        int c = 0;
        for (int i = 0; i < w; i++) if (v[i] && taps[i]) c++;
        return (v >> 1) | (32'(c % 2) << (w - 1));
    endfunction

    typedef struct {
        int          mode;   // 0 idle, 1 running, 2 frozen at terminal value
        logic [31:0] l;
        int          st;
        bit          hit;
        bit          lk;
        bit          per;
        logic [31:0] start;
    } m_t;

    function automatic m_t model_next(input m_t m, input logic [31:0] taps, input int w,
                                      input int cmax, input bit r, input bit sl,
                                      input logic [31:0] sd, input bit e, input bit me,
                                      input logic [31:0] mv);
        m_t n = m;
        n.lk  = 0;
        n.per = 0;
        if (r) begin
            n.mode = 0; n.l = 1; n.st = 0; n.hit = 0; n.start = 1;
        end else if (sl) begin
            n.l     = (sd == 0) ? 32'd1 : sd;
            n.lk    = (sd == 0);
            n.st    = 0;
            n.hit   = 0;
            n.mode  = 1;
            n.start = n.l;
        end else if (m.mode == 1 && e) begin
            n.l  = adv(m.l, taps, w);
            n.st = (m.st < cmax) ? m.st + 1 : cmax;
            if (me && n.l == mv) begin
                n.mode = 2;
                n.hit  = 1;
            end
            if (n.l == m.start) n.per = 1;
        end
        return n;
    endfunction

    typedef struct {
        bit          r, sl, e, me;
        logic [19:0] sd, mv;
        logic [19:0] x_lfsr;
        logic [1:0]  x_state;
        bit          x_hit;
        int          x_steps;
        bit          x_lk;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input bit r, sl, e, me, input logic [19:0] sd, mv,
                                input logic [19:0] xl, input logic [1:0] xs,
                                input bit xh, input int xst, input bit xlk);
        vec_t v;
        v.r = r; v.sl = sl; v.e = e; v.me = me; v.sd = sd; v.mv = mv;
        v.x_lfsr = xl; v.x_state = xs; v.x_hit = xh; v.x_steps = xst; v.x_lk = xlk;
        return v;
    endfunction

    m_t mm;

    initial begin
        rst = 1; seed_load = 0; en = 0; match_en = 0; seed = 0; match_val = 0;
        s_rst = 1; s_seed_load = 0; s_en = 0; s_seed = 0;

        // ---------------- directed table ----------------
        vt.push_back(mk(1, 0, 0, 0, 20'h0, 20'h0, 20'h00001, 2'd0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(0, 0, 1, 0, 20'h0, 20'h0, 20'h00001, 2'd0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 20'h00001, 20'h0, 20'h00001, 2'd1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 20'h0, 20'h0, 20'h80000, 2'd1, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 0, 20'h0, 20'h0, 20'h40000, 2'd1, 0, 2, 0));
        vt.push_back(mk(0, 1, 0, 0, 20'h0, 20'h0, 20'h00001, 2'd1, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 20'h0, 20'h0, 20'h00001, 2'd1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 20'h00001, 20'h40000, 20'h00001, 2'd1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 20'h0, 20'h40000, 20'h80000, 2'd1, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 1, 20'h0, 20'h40000, 20'h40000, 2'd2, 1, 2, 0));
        for (int i = 0; i < 10; i++)
            vt.push_back(mk(0, 0, 1, i % 2, 20'h0, 20'(i), 20'h40000, 2'd2, 1, 2, 0));
        vt.push_back(mk(0, 1, 1, 1, 20'h12345, 20'h0, 20'h12345, 2'd1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 20'h12345, 20'h12345, 20'h12345, 2'd1, 0, 0, 0));
        vt.push_back(mk(1, 1, 1, 0, 20'h54321, 20'h0, 20'h00001, 2'd0, 0, 0, 0));

        foreach (vt[k]) begin
            rst = vt[k].r; seed_load = vt[k].sl; en = vt[k].e;
            match_en = vt[k].me; seed = vt[k].sd; match_val = vt[k].mv;
            @(posedge clk); #1;
            chk($sformatf("vec%0d.lfsr", k), 32'(lfsr), 32'(vt[k].x_lfsr));
            chk($sformatf("vec%0d.state", k), 32'(state_o), 32'(vt[k].x_state));
            chk($sformatf("vec%0d.hit", k), 32'(hit), 32'(vt[k].x_hit));
            chk($sformatf("vec%0d.steps", k), 32'(steps), 32'(vt[k].x_steps));
            chk($sformatf("vec%0d.lockup", k), 32'(lockup), 32'(vt[k].x_lk));
        end

        // ---------------- small instance: saturation and period ----------------
        s_rst = 1; @(posedge clk); #1;
        s_rst = 0; s_seed_load = 1; s_seed = 4'h1; @(posedge clk); #1;
        chk("small.load", 32'(s_lfsr), 32'h1);
        s_seed_load = 0; s_en = 1;
        mm = '{mode: 1, l: 1, st: 0, hit: 0, lk: 0, per: 0, start: 1};
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            mm = model_next(mm, 32'h3, 4, 15, 0, 0, 0, 1, 0, 0);
            chk($sformatf("small.steps%0d", k), 32'(s_steps), (k < 15) ? k : 15);
            chk($sformatf("small.lfsr%0d", k), 32'(s_lfsr), mm.l);
            if (k == 15) chk("small.wrap", 32'(s_lfsr), 32'h1);
`ifdef LFSR_PERIOD_EN
            chk($sformatf("small.period%0d", k), 32'(s_period), (k == 15) ? 1 : 0);
`endif
        end
        s_en = 0;

        // ---------------- randomized run against the model ----------------
        rst = 1; seed_load = 0; en = 0; match_en = 0;
        mm = '{mode: 0, l: 1, st: 0, hit: 0, lk: 0, per: 0, start: 1};
        for (int k = 0; k < 3000; k++) begin
            if (k > 0) rst = ($urandom_range(0, 63) == 0);
            seed_load = ($urandom_range(0, 15) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 20'h0 : 20'($urandom);
            en        = ($urandom_range(0, 3) != 0);
            match_en  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) begin
                logic [31:0] t = mm.l;
                int ahead = $urandom_range(1, 6);
                for (int j = 0; j < ahead; j++) t = adv(t, 32'h08881, 20);
                match_val = t[19:0];
            end else if ($urandom_range(0, 31) == 0) begin
                match_val = 20'($urandom);
            end
            mm = model_next(mm, 32'h08881, 20, 65535, rst, seed_load, 32'(seed),
                            en, match_en, 32'(match_val));
            @(posedge clk); #1;
            chk($sformatf("rnd%0d.lfsr", k), 32'(lfsr), mm.l);
            chk($sformatf("rnd%0d.state", k), 32'(state_o), 32'(mm.mode));
            chk($sformatf("rnd%0d.hit", k), 32'(hit), 32'(mm.hit));
            chk($sformatf("rnd%0d.steps", k), 32'(steps), 32'(mm.st));
            chk($sformatf("rnd%0d.lockup", k), 32'(lockup), 32'(mm.lk));
`ifdef LFSR_PERIOD_EN
            chk($sformatf("rnd%0d.period", k), 32'(period), 32'(mm.per));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
